second_game_ctrl: RTL and testbench

Sequencer for the dodge-game obstacle engine (right half of screen). Owns the game FSM (idle, countdown, play, gameover, optional pause) and generates the obstacle scroll tick with level-based speed-up. Keeps the score and serves random gap-position requests from the engine via a 1-cycle request/valid handshake. Frame-paced by the VGA frame-start pulse.

---
 rtl/second_game_pkg.sv | 22 ++
 rtl/second_game_lfsr.sv | 24 ++
 rtl/second_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_second_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/second_game_pkg.sv
// second_game_pkg: state codes, LFSR taps and scroll-speed helper shared by the dodge-game sequencer.
package second_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_GAMEOVER  = 3'd3,
        ST_PAUSE     = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          CNT_W     = 16;

    // Frames per scroll tick; each level shaves one frame off, clamped at the floor.
    function automatic int scroll_period(input logic [3:0] level, input int init_p, input int min_p);
        int p;
        p = init_p - int'(level);
        return (p < min_p) ? min_p : p;
    endfunction

endpackage

// File: rtl/second_game_lfsr.sv
// second_game_lfsr: 16-bit Galois LFSR used as the gap-position random source.
module second_game_lfsr
    import second_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            lfsr_q <= SEED;
        else if (en_i)
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/second_game_ctrl.sv
// second_game_ctrl: game FSM, frame-paced scroll tick with level speed-up, score and random gap server.
// Define SECOND_GAME_CTRL_PAUSE_EN to enable the PAUSE state driven by i_pause.
module second_game_ctrl
    import second_game_pkg::*;
#(
    parameter int          COUNTDOWN_FRAMES = 180,
    parameter int          HOLD_FRAMES      = 120,
    parameter int          INIT_PERIOD      = 8,
    parameter int          MIN_PERIOD       = 1,
    parameter int          LEVEL_UP_SCORE   = 10,
    parameter int          SCORE_W          = 10,
    parameter int          GAP_MIN          = 20,
    parameter int          GAP_MASK         = 255,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_frame_start,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_collision,
    input  logic               i_obstacle_passed,
    input  logic               i_gap_req,
    output logic               o_gap_valid,
    output logic [8:0]         o_gap_x,
    output logic               o_scroll_tick,
    output logic               o_engine_clr,
    output logic               o_engine_run,
    output logic [2:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic [3:0]         o_level,
    output logic               o_is_gameover
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, div_q, div_d, step_q, step_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         level_q, level_d;
    logic               start_prev_q, clr_q, clr_d, tick_q, tick_d, gap_valid_q;
    logic [8:0]         gap_x_q;
    logic [15:0]        lfsr;
    logic [6:0]         unused_lfsr_hi;
    logic               start_edge;
    int                 period;

    second_game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .arst_n (arst_n),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign unused_lfsr_hi = lfsr[15:9];
    assign start_edge     = i_start & ~start_prev_q;
    assign period         = scroll_period(level_q, INIT_PERIOD, MIN_PERIOD);

`ifdef SECOND_GAME_CTRL_PAUSE_EN
    logic pause_prev_q, pause_edge;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            pause_prev_q <= 1'b0;
        else
            pause_prev_q <= i_pause;
    end
    assign pause_edge = i_pause & ~pause_prev_q;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
`endif

    // cnt doubles as the countdown timer and the game-over hold timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        step_d  = step_q;
        score_d = score_q;
        level_d = level_q;
        clr_d   = 1'b0;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: clr_d = start_edge;
            ST_COUNTDOWN: if (i_frame_start) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q <= CNT_W'(1)) ? ST_PLAY : ST_COUNTDOWN;
            end
            ST_PLAY: if (i_collision) begin
                state_d = ST_GAMEOVER;
                cnt_d   = CNT_W'(HOLD_FRAMES);
            end
`ifdef SECOND_GAME_CTRL_PAUSE_EN
            else if (pause_edge) state_d = ST_PAUSE;
`endif
            else begin
                if (i_frame_start) begin
                    tick_d = int'(div_q) >= period - 1;
                    div_d  = tick_d ? '0 : div_q + 1'b1;
                end
                if (i_obstacle_passed) begin
                    score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                    step_d  = (int'(step_q) + 1 >= LEVEL_UP_SCORE) ? '0 : step_q + 1'b1;
                    level_d = (step_d == '0 && level_q != 4'hF) ? level_q + 1'b1 : level_q;
                end
            end
            ST_GAMEOVER: begin
                clr_d = start_edge && cnt_q == '0;
                if (i_frame_start && cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
`ifdef SECOND_GAME_CTRL_PAUSE_EN
            ST_PAUSE: if (pause_edge) state_d = ST_PLAY;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (clr_d) begin
            state_d = ST_COUNTDOWN;
            cnt_d   = CNT_W'(COUNTDOWN_FRAMES);
            div_d   = '0;
            step_d  = '0;
            score_d = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            step_q       <= '0;
            score_q      <= '0;
            level_q      <= '0;
            start_prev_q <= 1'b0;
            clr_q        <= 1'b0;
            tick_q       <= 1'b0;
            gap_valid_q  <= 1'b0;
            gap_x_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            step_q       <= step_d;
            score_q      <= score_d;
            level_q      <= level_d;
            start_prev_q <= i_start;
            clr_q        <= clr_d;
            tick_q       <= tick_d;
            gap_valid_q  <= i_gap_req;
            if (i_gap_req) gap_x_q <= 9'(GAP_MIN) + (lfsr[8:0] & 9'(GAP_MASK));
        end
    end

    assign o_gap_valid   = gap_valid_q;
    assign o_gap_x       = gap_x_q;
    assign o_scroll_tick = tick_q;
    assign o_engine_clr  = clr_q;
    assign o_engine_run  = state_q == ST_PLAY;
    assign o_state       = state_q;
    assign o_score       = score_q;
    assign o_level       = level_q;
    assign o_is_gameover = state_q == ST_GAMEOVER;

endmodule

// File: tb/tb_second_game_ctrl.sv
// tb_second_game_ctrl: vector table, directed corner sequences and a random run against a game-rules model.
module tb_second_game_ctrl;

    localparam int CD = 3, HOLD = 5, INIT = 4, MINP = 1, LUS = 2, SW = 10, GMIN = 20, GMASK = 255;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 0, arst_n = 0;
    logic frame = 0, start = 0, pause = 0, coll = 0, passed = 0, gap_req = 0;
    logic gap_valid, tick, clr, run, gameover;
    logic [8:0] gap_x;
    logic [2:0] state;
    logic [SW-1:0] score;
    logic [3:0] level;

    int checks = 0, errors = 0, tick_cnt = 0, gv_cnt = 0;
    int m_state, m_cd, m_hold, m_frames, m_passes, m_lfsr, e_gx;
    bit m_ps, m_pp, e_clr, e_tick, e_gv;

    typedef struct {
        bit st, fr, co, pa;
        int state, clr, tick, score, level;
    } vec_t;
    vec_t tbl[26];

    always #5 clk = ~clk;

    second_game_ctrl #(
        .COUNTDOWN_FRAMES(CD), .HOLD_FRAMES(HOLD), .INIT_PERIOD(INIT), .MIN_PERIOD(MINP),
        .LEVEL_UP_SCORE(LUS), .SCORE_W(SW), .GAP_MIN(GMIN), .GAP_MASK(GMASK), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_frame_start(frame), .i_start(start), .i_pause(pause),
        .i_collision(coll), .i_obstacle_passed(passed), .i_gap_req(gap_req),
        .o_gap_valid(gap_valid), .o_gap_x(gap_x), .o_scroll_tick(tick), .o_engine_clr(clr),
        .o_engine_run(run), .o_state(state), .o_score(score), .o_level(level),
        .o_is_gameover(gameover)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int lvl_of(input int p);
        return (p / LUS > 15) ? 15 : p / LUS;
    endfunction

    function automatic int score_of(input int p);
        return (p > SMAX) ? SMAX : p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cd = 0; m_hold = 0; m_frames = 0; m_passes = 0;
        m_lfsr = SEED; e_gx = 0; m_ps = 0; m_pp = 0; e_clr = 0; e_tick = 0; e_gv = 0;
    endtask

    task automatic begin_game();
        m_state = 1; m_cd = CD; m_passes = 0; m_frames = 0; e_clr = 1;
    endtask

    // Game rules applied once per clock edge to the inputs held during that cycle.
    task automatic model_edge();
        bit se, pe;
        int per;
        se = start & ~m_ps;
        pe = pause & ~m_pp;
        per = INIT - lvl_of(m_passes);
        if (per < MINP) per = MINP;
        e_clr = 0;
        e_tick = 0;
        e_gv = gap_req;
        if (gap_req) e_gx = GMIN + ((m_lfsr % 512) & GMASK);
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 0);
        case (m_state)
            0: if (se) begin_game();
            1: if (frame) begin
                m_cd--;
                if (m_cd <= 0) m_state = 2;
            end
            2: if (coll) begin
                m_state = 3;
                m_hold = HOLD;
            end
`ifdef SECOND_GAME_CTRL_PAUSE_EN
            else if (pe) m_state = 4;
`endif
            else begin
                if (frame) begin
                    m_frames++;
                    if (m_frames >= per) begin e_tick = 1; m_frames = 0; end
                end
                if (passed) m_passes++;
            end
            3: if (se && m_hold == 0) begin_game();
               else if (frame && m_hold > 0) m_hold--;
            4: if (pe) m_state = 2;
            default: m_state = 0;
        endcase
        m_ps = start;
        m_pp = pause;
    endtask

    task automatic compare_model();
        check("state", state, m_state);
        check("run", run, m_state == 2);
        check("gameover", gameover, m_state == 3);
        check("score", score, score_of(m_passes));
        check("level", level, lvl_of(m_passes));
        check("scroll_tick", tick, e_tick);
        check("engine_clr", clr, e_clr);
        check("gap_valid", gap_valid, e_gv);
        if (e_gv) begin
            check("gap_x", gap_x, e_gx);
            check("gap_range", (gap_x >= GMIN && gap_x <= GMIN + GMASK), 1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        tick_cnt += int'(tick);
        gv_cnt += int'(gap_valid);
    endtask

    task automatic pulse_frame();
        frame = 1; cyc();
        frame = 0; cyc();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_clr"}, clr, 0);
        check({tag, "_run"}, run, 0);
        check({tag, "_gameover"}, gameover, 0);
        check({tag, "_gap_valid"}, gap_valid, 0);
        check({tag, "_gap_x"}, gap_x, 0);
    endtask

    task automatic set_row(input int i, input bit st, fr, co, pa, input int s, c, t, sc, lv);
        tbl[i] = '{st, fr, co, pa, s, c, t, sc, lv};
    endtask

    initial begin
        set_row(0,  0,0,0,0, 0,0,0,0,0);
        set_row(1,  1,0,0,0, 1,1,0,0,0);
        set_row(2,  1,0,0,0, 1,0,0,0,0);
        set_row(3,  0,1,0,0, 1,0,0,0,0);
        set_row(4,  0,0,0,0, 1,0,0,0,0);
        set_row(5,  0,1,0,0, 1,0,0,0,0);
        set_row(6,  1,1,1,0, 2,0,0,0,0);
        set_row(7,  0,0,0,0, 2,0,0,0,0);
        set_row(8,  0,1,0,0, 2,0,0,0,0);
        set_row(9,  0,1,0,0, 2,0,0,0,0);
        set_row(10, 0,1,0,0, 2,0,0,0,0);
        set_row(11, 0,1,0,0, 2,0,1,0,0);
        set_row(12, 0,0,0,0, 2,0,0,0,0);
        set_row(13, 0,0,0,1, 2,0,0,1,0);
        set_row(14, 0,0,0,1, 2,0,0,2,1);
        set_row(15, 0,1,0,0, 2,0,0,2,1);
        set_row(16, 0,1,0,0, 2,0,0,2,1);
        set_row(17, 0,1,0,0, 2,0,1,2,1);
        set_row(18, 0,0,1,1, 3,0,0,2,1);
        set_row(19, 1,0,0,0, 3,0,0,2,1);
        set_row(20, 0,1,0,0, 3,0,0,2,1);
        set_row(21, 0,1,0,0, 3,0,0,2,1);
        set_row(22, 0,1,0,0, 3,0,0,2,1);
        set_row(23, 1,1,0,0, 3,0,0,2,1);
        set_row(24, 0,1,0,0, 3,0,0,2,1);
        set_row(25, 1,0,0,0, 1,1,0,0,0);

        #23;
        reset_checks("reset");
        model_reset();
        @(posedge clk); #1;
        arst_n = 1;

        foreach (tbl[i]) begin
            start = tbl[i].st; frame = tbl[i].fr; coll = tbl[i].co; passed = tbl[i].pa;
            cyc();
            check($sformatf("tbl%0d_state", i), state, tbl[i].state);
            check($sformatf("tbl%0d_clr", i), clr, tbl[i].clr);
            check($sformatf("tbl%0d_tick", i), tick, tbl[i].tick);
            check($sformatf("tbl%0d_score", i), score, tbl[i].score);
            check($sformatf("tbl%0d_level", i), level, tbl[i].level);
            check($sformatf("tbl%0d_run", i), run, tbl[i].state == 2);
            check($sformatf("tbl%0d_gameover", i), gameover, tbl[i].state == 3);
        end
        start = 0; frame = 0; coll = 0; passed = 0;

        repeat (3) pulse_frame();
        check("cd_to_play_state", state, 2);
        check("cd_to_play_run", run, 1);

        tick_cnt = 0;
        repeat (12) pulse_frame();
        check("ticks_period4", tick_cnt, 3);

        passed = 1; repeat (4) cyc(); passed = 0;
        check("score_after4", score, 4);
        check("level_after4", level, 2);
        tick_cnt = 0;
        repeat (6) pulse_frame();
        check("ticks_period2", tick_cnt, 3);

        passed = 1; repeat (6) cyc(); passed = 0;
        check("level_after10", level, 5);
        tick_cnt = 0;
        repeat (4) pulse_frame();
        check("ticks_min_period", tick_cnt, 4);

        passed = 1; repeat (1020) cyc(); passed = 0;
        check("score_saturated", score, SMAX);
        check("level_saturated", level, 15);

`ifdef SECOND_GAME_CTRL_PAUSE_EN
        pause = 1; cyc(); pause = 0;
        check("pause_state", state, 4);
        tick_cnt = 0;
        coll = 1;
        repeat (20) pulse_frame();
        coll = 0;
        check("pause_ticks", tick_cnt, 0);
        check("pause_hold_state", state, 4);
        pause = 1; cyc(); pause = 0;
        check("unpause_state", state, 2);
`endif

        coll = 1; cyc(); coll = 0;
        check("collision_state", state, 3);

        gv_cnt = 0;
        gap_req = 1; repeat (3) cyc(); gap_req = 0; cyc();
        check("gap_burst_count", gv_cnt, 3);

        for (int i = 0; i < 3000; i++) begin
            frame   = $urandom_range(0, 3) == 0;
            coll    = $urandom_range(0, 39) == 0;
            passed  = $urandom_range(0, 5) == 0;
            gap_req = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 15) == 0) start = ~start;
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            if (i == 1500) gap_req = 1;
            cyc();
            if (i == 1500) begin
                arst_n = 0;
                #1;
                reset_checks("midreset");
                model_reset();
                @(posedge clk); #1;
                arst_n = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
